// File: rtl/sys_ctrl_pkg.sv
//------------------------------------------------------------------------------
// sys_ctrl_pkg : command bytes, FSM encodings and RF operand slots shared by
//                the SYS_TOP command decoder and its TX sequencer.
// Revision     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package sys_ctrl_pkg;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WR_ADDR  = 4'd1,
    ST_WR_DATA  = 4'd2,
    ST_RD_ADDR  = 4'd3,
    ST_RD_WAIT  = 4'd4,
    ST_ALU_A    = 4'd5,
    ST_ALU_B    = 4'd6,
    ST_ALU_FUN  = 4'd7,
    ST_ALU_WAIT = 4'd8,
    ST_TX       = 4'd9
  } ctrl_state_e;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_LO   = 2'd1,
    TX_HI   = 2'd2
  } tx_state_e;

  // States that are waiting for the next frame of a command.
  function automatic logic is_frame_state(input ctrl_state_e s);
    return (s == ST_WR_ADDR) || (s == ST_WR_DATA) || (s == ST_RD_ADDR) ||
           (s == ST_ALU_A)   || (s == ST_ALU_B)   || (s == ST_ALU_FUN);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sys_ctrl_tx_sequencer.sv
//------------------------------------------------------------------------------
// sys_ctrl_tx_sequencer : sends a one- or two-byte result to the UART TX,
//                         handshaking each byte on a TX_BUSY high-then-low.
// Revision              : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module sys_ctrl_tx_sequencer
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    start_i,
  input  logic                    two_byte_i,
  input  logic [2*DATA_WIDTH-1:0] data_i,
  input  logic                    tx_busy_i,
  output logic [DATA_WIDTH-1:0]   tx_data_o,
  output logic                    tx_vld_o,
  output logic                    busy_o
);

  tx_state_e                 state_q, state_d;
  logic [2*DATA_WIDTH-1:0]   buf_q, buf_d;
  logic                      two_q, two_d;
  logic                      sent_q, sent_d;
  logic                      seen_q, seen_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic                      vld_q, vld_d;
  logic                      w_active;

  assign w_active = (state_q == TX_LO) || (state_q == TX_HI);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= TX_IDLE;
      buf_q   <= '0;
      two_q   <= 1'b0;
      sent_q  <= 1'b0;
      seen_q  <= 1'b0;
      data_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      two_q   <= two_d;
      sent_q  <= sent_d;
      seen_q  <= seen_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
    end
  end

  // Each byte: issue when TX is idle, then wait for busy to rise and fall.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    two_d   = two_q;
    sent_d  = sent_q;
    seen_d  = seen_q;
    case (state_q)
      TX_IDLE: begin
        if (start_i) begin
          buf_d   = data_i;
          two_d   = two_byte_i;
          sent_d  = 1'b0;
          seen_d  = 1'b0;
          state_d = TX_LO;
        end
      end
      TX_LO, TX_HI: begin
        if (!sent_q) begin
          if (!tx_busy_i) sent_d = 1'b1;
        end else if (!seen_q) begin
          if (tx_busy_i) seen_d = 1'b1;
        end else if (!tx_busy_i) begin
          sent_d  = 1'b0;
          seen_d  = 1'b0;
          state_d = ((state_q == TX_LO) && two_q) ? TX_HI : TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    vld_d  = 1'b0;
    data_d = data_q;
    if (w_active && !sent_q && !tx_busy_i) begin
      vld_d  = 1'b1;
      data_d = (state_q == TX_HI) ? buf_q[2*DATA_WIDTH-1:DATA_WIDTH] : buf_q[DATA_WIDTH-1:0];
    end
  end

  assign tx_data_o = data_q;
  assign tx_vld_o  = vld_q;
  assign busy_o    = (state_q != TX_IDLE);

endmodule

`default_nettype wire

// File: rtl/sys_ctrl_cmd_decoder.sv
//------------------------------------------------------------------------------
// sys_ctrl_cmd_decoder : decodes UART command frames into RF/ALU control and
//                        returns results to the UART TX. Optional inter-frame
//                        timeout enabled by SYS_CTRL_TIMEOUT_EN.
// Revision             : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module sys_ctrl_cmd_decoder
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  input  logic                    RX_ERROR,
  output logic                    RF_WrEn,
  output logic                    RF_RdEn,
  output logic [ADDR_WIDTH-1:0]   RF_Address,
  output logic [DATA_WIDTH-1:0]   RF_WrData,
  input  logic [DATA_WIDTH-1:0]   RF_RdData,
  input  logic                    RF_RdData_VLD,
  output logic                    ALU_EN,
  output logic [3:0]              ALU_FUN,
  output logic                    CLK_GATE_EN,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  input  logic                    TX_BUSY
);

  ctrl_state_e              state_q, state_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wrdata_q, wrdata_d;
  logic                     wr_en_q, wr_en_d;
  logic                     rd_en_q, rd_en_d;
  logic                     alu_en_q, alu_en_d;
  logic [3:0]               alu_fun_q, alu_fun_d;
  logic                     gate_q, gate_d;

  logic                     w_accept;
  logic                     w_rx_err;
  logic                     w_timeout;
  logic                     w_seq_start;
  logic                     w_seq_two;
  logic [2*DATA_WIDTH-1:0]  w_seq_data;
  logic                     w_seq_busy;

  assign w_accept = RX_D_VLD && !RX_ERROR;
  assign w_rx_err = RX_D_VLD && RX_ERROR;

`ifdef SYS_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign w_timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == ST_IDLE) || w_accept) begin
      cnt_d = '0;
    end else if (is_frame_state(state_q) && !w_timeout) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  // No timeout in this build; the expression is constant false.
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wrdata_q  <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      alu_en_q  <= 1'b0;
      alu_fun_q <= '0;
      gate_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wrdata_q  <= wrdata_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      alu_en_q  <= alu_en_d;
      alu_fun_q <= alu_fun_d;
      gate_q    <= gate_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          case (RX_P_DATA[7:0])
            CMD_RF_WR:   state_d = ST_WR_ADDR;
            CMD_RF_RD:   state_d = ST_RD_ADDR;
            CMD_ALU_OP:  state_d = ST_ALU_A;
            CMD_ALU_NOP: state_d = ST_ALU_FUN;
            default:     state_d = ST_IDLE;
          endcase
        end
      end
      ST_WR_ADDR:  if (w_accept) state_d = ST_WR_DATA;
      ST_WR_DATA:  if (w_accept) state_d = ST_IDLE;
      ST_RD_ADDR:  if (w_accept) state_d = ST_RD_WAIT;
      ST_RD_WAIT:  if (RF_RdData_VLD) state_d = ST_TX;
      ST_ALU_A:    if (w_accept) state_d = ST_ALU_B;
      ST_ALU_B:    if (w_accept) state_d = ST_ALU_FUN;
      ST_ALU_FUN:  if (w_accept) state_d = ST_ALU_WAIT;
      ST_ALU_WAIT: if (ALU_OUT_VLD) state_d = ST_TX;
      ST_TX:       if (!w_seq_busy) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    // Errors and timeouts abort only while a command is still collecting frames.
    if (is_frame_state(state_q) && (w_rx_err || (w_timeout && !w_accept))) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    addr_d    = addr_q;
    wrdata_d  = wrdata_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    alu_en_d  = 1'b0;
    alu_fun_d = alu_fun_q;
    gate_d    = gate_q;
    case (state_q)
      ST_WR_ADDR: if (w_accept) addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
      ST_WR_DATA: begin
        if (w_accept) begin
          wrdata_d = RX_P_DATA;
          wr_en_d  = 1'b1;
        end
      end
      ST_RD_ADDR: begin
        if (w_accept) begin
          addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
          rd_en_d = 1'b1;
        end
      end
      ST_ALU_A: begin
        if (w_accept) begin
          addr_d   = ADDR_WIDTH'(OPA_ADDR);
          wrdata_d = RX_P_DATA;
          wr_en_d  = 1'b1;
        end
      end
      ST_ALU_B: begin
        if (w_accept) begin
          addr_d   = ADDR_WIDTH'(OPB_ADDR);
          wrdata_d = RX_P_DATA;
          wr_en_d  = 1'b1;
        end
      end
      ST_ALU_FUN: begin
        if (w_accept) begin
          alu_fun_d = RX_P_DATA[3:0];
          alu_en_d  = 1'b1;
          gate_d    = 1'b1;
        end
      end
      ST_ALU_WAIT: if (ALU_OUT_VLD) gate_d = 1'b0;
      default: ;
    endcase
  end

  assign w_seq_start = ((state_q == ST_RD_WAIT) && RF_RdData_VLD) ||
                       ((state_q == ST_ALU_WAIT) && ALU_OUT_VLD);
  assign w_seq_two   = (state_q == ST_ALU_WAIT);
  assign w_seq_data  = w_seq_two ? ALU_OUT : {{DATA_WIDTH{1'b0}}, RF_RdData};

  sys_ctrl_tx_sequencer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_tx_seq (
    .CLK        (CLK),
    .RST        (RST),
    .start_i    (w_seq_start),
    .two_byte_i (w_seq_two),
    .data_i     (w_seq_data),
    .tx_busy_i  (TX_BUSY),
    .tx_data_o  (TX_P_DATA),
    .tx_vld_o   (TX_D_VLD),
    .busy_o     (w_seq_busy)
  );

  assign RF_WrEn     = wr_en_q;
  assign RF_RdEn     = rd_en_q;
  assign RF_Address  = addr_q;
  assign RF_WrData   = wrdata_q;
  assign ALU_EN      = alu_en_q;
  assign ALU_FUN     = alu_fun_q;
  assign CLK_GATE_EN = gate_q;

endmodule

`default_nettype wire

// File: tb/tb_sys_ctrl_cmd_decoder.sv
//------------------------------------------------------------------------------
// tb_sys_ctrl_cmd_decoder : scoreboard bench with RF, ALU and UART-TX models.
// Revision                : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sys_ctrl_cmd_decoder;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] RX_P_DATA;
  logic          RX_D_VLD;
  logic          RX_ERROR;
  logic          RF_WrEn;
  logic          RF_RdEn;
  logic [AW-1:0] RF_Address;
  logic [DW-1:0] RF_WrData;
  logic [DW-1:0] RF_RdData;
  logic          RF_RdData_VLD;
  logic          ALU_EN;
  logic [3:0]    ALU_FUN;
  logic          CLK_GATE_EN;
  logic [2*DW-1:0] ALU_OUT;
  logic          ALU_OUT_VLD;
  logic [DW-1:0] TX_P_DATA;
  logic          TX_D_VLD;
  logic          TX_BUSY;

  always #5 CLK = ~CLK;

  sys_ctrl_cmd_decoder #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .RX_P_DATA     (RX_P_DATA),
    .RX_D_VLD      (RX_D_VLD),
    .RX_ERROR      (RX_ERROR),
    .RF_WrEn       (RF_WrEn),
    .RF_RdEn       (RF_RdEn),
    .RF_Address    (RF_Address),
    .RF_WrData     (RF_WrData),
    .RF_RdData     (RF_RdData),
    .RF_RdData_VLD (RF_RdData_VLD),
    .ALU_EN        (ALU_EN),
    .ALU_FUN       (ALU_FUN),
    .CLK_GATE_EN   (CLK_GATE_EN),
    .ALU_OUT       (ALU_OUT),
    .ALU_OUT_VLD   (ALU_OUT_VLD),
    .TX_P_DATA     (TX_P_DATA),
    .TX_D_VLD      (TX_D_VLD),
    .TX_BUSY       (TX_BUSY)
  );

  int total = 0;
  int bad   = 0;

  logic [11:0] exp_wr[$];
  logic [3:0]  exp_rd[$];
  logic [3:0]  exp_alu[$];
  logic [7:0]  exp_tx[$];

  logic [7:0]  rf_mem [16];
  logic [15:0] alu_result;
  int          alu_cnt = -1;
  int          busy_cnt = 0;
  logic        tx_pending = 1'b0;
  logic        tx_outstanding = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic err = 1'b0);
    @(negedge CLK);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    RX_ERROR  = err;
    @(negedge CLK);
    RX_D_VLD  = 1'b0;
    RX_ERROR  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (exp_wr.size() == 0 && exp_rd.size() == 0 && exp_alu.size() == 0 &&
          exp_tx.size() == 0 && !TX_BUSY && !tx_pending && alu_cnt < 0) break;
    end
    repeat (4) @(negedge CLK);
    check("scoreboard_empty", exp_wr.size() + exp_rd.size() + exp_alu.size() + exp_tx.size(), 0);
  endtask

  // Environment models and output scoreboard, all sampled on the falling edge.
  initial begin
    logic [11:0] ew;
    RF_RdData     = '0;
    RF_RdData_VLD = 1'b0;
    ALU_OUT       = '0;
    ALU_OUT_VLD   = 1'b0;
    TX_BUSY       = 1'b0;
    for (int i = 0; i < 16; i++) rf_mem[i] = '0;
    forever begin
      @(negedge CLK);
      RF_RdData_VLD = 1'b0;
      ALU_OUT_VLD   = 1'b0;
      if (RST) begin
        alu_cnt = -1; busy_cnt = 0; TX_BUSY = 1'b0;
        tx_pending = 1'b0; tx_outstanding = 1'b0;
      end else begin
        if (RF_WrEn) begin
          check("wr_expected", exp_wr.size() > 0, 1);
          if (exp_wr.size() > 0) begin
            ew = exp_wr.pop_front();
            check("wr_addr", RF_Address, ew[11:8]);
            check("wr_data", RF_WrData, ew[7:0]);
          end
          rf_mem[RF_Address] = RF_WrData;
        end
        if (RF_RdEn) begin
          check("rd_expected", exp_rd.size() > 0, 1);
          if (exp_rd.size() > 0) check("rd_addr", RF_Address, exp_rd.pop_front());
          RF_RdData     = rf_mem[RF_Address];
          RF_RdData_VLD = 1'b1;
        end
        if (ALU_EN) begin
          check("alu_expected", exp_alu.size() > 0, 1);
          if (exp_alu.size() > 0) check("alu_fun", ALU_FUN, exp_alu.pop_front());
          check("alu_gate_on", CLK_GATE_EN, 1);
          alu_cnt = 3;
        end else if (alu_cnt > 0) begin
          check("gate_during_wait", CLK_GATE_EN, 1);
          alu_cnt--;
        end else if (alu_cnt == 0) begin
          ALU_OUT     = alu_result;
          ALU_OUT_VLD = 1'b1;
          alu_cnt     = -1;
        end
        if (TX_D_VLD) begin
          check("tx_expected", exp_tx.size() > 0, 1);
          if (exp_tx.size() > 0) check("tx_byte", TX_P_DATA, exp_tx.pop_front());
          check("tx_busy_clear", TX_BUSY, 0);
          check("tx_overlap", tx_outstanding, 0);
          tx_pending     = 1'b1;
          tx_outstanding = 1'b1;
        end else if (tx_pending) begin
          TX_BUSY    = 1'b1;
          busy_cnt   = 6;
          tx_pending = 1'b0;
        end else if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) begin
            TX_BUSY        = 1'b0;
            tx_outstanding = 1'b0;
          end
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wren"},  RF_WrEn, 0);
    check({tag, "_rden"},  RF_RdEn, 0);
    check({tag, "_addr"},  RF_Address, 0);
    check({tag, "_wdata"}, RF_WrData, 0);
    check({tag, "_aluen"}, ALU_EN, 0);
    check({tag, "_fun"},   ALU_FUN, 0);
    check({tag, "_gate"},  CLK_GATE_EN, 0);
    check({tag, "_txv"},   TX_D_VLD, 0);
    check({tag, "_txd"},   TX_P_DATA, 0);
  endtask

  initial begin
    RST = 1'b1; RX_P_DATA = '0; RX_D_VLD = 1'b0; RX_ERROR = 1'b0; alu_result = '0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("rst");
    RST = 1'b0;

    // RF write
    exp_wr.push_back({4'h5, 8'hA6});
    send(8'hAA); send(8'h05); send(8'hA6);
    drain();

    // RF read returns the value just written
    exp_rd.push_back(4'h5);
    exp_tx.push_back(8'hA6);
    send(8'hBB); send(8'h05);
    drain();

    // ALU with operands
    alu_result = 16'h0007;
    exp_wr.push_back({4'h0, 8'h03});
    exp_wr.push_back({4'h1, 8'h04});
    exp_alu.push_back(4'h0);
    exp_tx.push_back(8'h07);
    exp_tx.push_back(8'h00);
    send(8'hCC); send(8'h03); send(8'h04); send(8'h00);
    drain();
    check("gate_off_after_op", CLK_GATE_EN, 0);

    // RX error aborts the write; trailing byte is an unknown command
    send(8'hAA); send(8'h05, 1'b1); send(8'hA6);
    drain();
    exp_wr.push_back({4'h3, 8'h5A});
    send(8'hAA); send(8'h03); send(8'h5A);
    drain();

    // Unknown byte, then ALU without operands
    alu_result = 16'h1234;
    exp_alu.push_back(4'h2);
    exp_tx.push_back(8'h34);
    exp_tx.push_back(8'h12);
    send(8'h55); send(8'hDD); send(8'h02);
    drain();
    check("gate_off_after_nop", CLK_GATE_EN, 0);
    check("fun_hold", ALU_FUN, 4'h2);

    // Bytes (errored and clean) arriving while waiting on the ALU are ignored
    alu_result = 16'hBEEF;
    exp_alu.push_back(4'h9);
    exp_tx.push_back(8'hEF);
    exp_tx.push_back(8'hBE);
    send(8'hDD); send(8'h09); send(8'hAA, 1'b1); send(8'hBB);
    drain();

    // Reset mid-command clears outputs and discards the partial command
    exp_wr.push_back({4'h0, 8'h03});
    send(8'hCC); send(8'h03);
    @(negedge CLK); RST = 1'b1;
    repeat (2) @(negedge CLK);
    check_reset_outputs("midrst");
    RST = 1'b0;
    send(8'h04);
    drain();

`ifdef SYS_CTRL_TIMEOUT_EN
    exp_wr.push_back({4'h6, 8'h11});
    send(8'hAA); send(8'h05);
    repeat (101) @(negedge CLK);
    send(8'hAA); send(8'h06); send(8'h11);
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got=running expected=done");
    $fatal(1);
  end

endmodule

`default_nettype wire
